seg7_scan_display: RTL and testbench
====================================

# seg7_scan_display

Time-multiplexed driver for the calculator's 4-digit common-anode seven-segment display. Consumes the one-cycle refresh tick from the design's clock-divider path, scans one digit per tick with an anti-ghosting blank interval, and accepts new 16-bit hex values over a valid/ready handshake. Values are double-buffered and applied only at frame boundaries, so a digit never changes mid-frame.

## Interface
Parameters:
- BLANK_CYCLES, 16, clk cycles with all anodes off before each digit is driven; legal range 1..255, must be less than the tick period.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- refresh_tick  in  1  single-cycle scan-advance pulse.
- value_in  in  16  four hex nibbles; [3:0] is digit 0, the rightmost digit.
- dp_in  in  4  decimal-point request per digit, sampled with value_in.
- value_valid  in  1  producer offers value_in/dp_in.
- value_ready  out  1  pending buffer empty; the transfer happens on valid&ready.
- an  out  4  anodes, active-low.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - active: 16-bit value + 4-bit dp, the contents being displayed.
  - pending: 16-bit value + 4-bit dp, plus a full flag.
  - idx: 2-bit digit index.
  - blank counter: 8-bit.
- FSM states:
  - WAIT: reset state. Output is all off.
  - BLANK: an=4'b1111, seg=7'h7F, dp=1. Counts BLANK_CYCLES, then goes to DRIVE.
  - DRIVE: an has bit idx low. seg and dp show the active nibble idx.
- Transitions:
  - WAIT + tick → BLANK with idx=0. This counts as a frame boundary.
  - DRIVE + tick → BLANK with idx=(idx+1) mod 4. The 3→0 wrap is a frame boundary.
  - A tick in BLANK is ignored: idx does not advance and no boundary occurs.
- Frame boundary:
  - frame_done pulses.
  - If pending is full, pending is copied to active and the full flag clears.
- Handshake:
  - value_ready = !pending_full, registered.
  - On valid&ready, pending loads and value_ready drops the next cycle.
  - A handshake in the same cycle as a boundary goes to pending. It is not bypassed into active and is shown from the following frame.
- Decode: hex 0–F via the standard 7-segment font. Examples: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110.
- Reset mid-operation: all registers return to their reset values immediately and any pending value is discarded.

## Timing
- Reset values:
  - an=4'b1111, seg=7'h7F, dp=1.
  - value_ready=1, frame_done=0.
  - active=0, pending empty, idx=0, state WAIT.
- All outputs are registered.
- The state change is visible the cycle after tick is sampled.
- BLANK lasts exactly BLANK_CYCLES cycles.
- DRIVE holds until the next accepted tick.
- frame_done is high for the single cycle after the boundary tick edge. The active update takes effect on that same edge.
- value_ready re-asserts the cycle after the boundary that emptied pending.
- A value accepted at cycle t is displayed no later than the first DRIVE of the second subsequent frame.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - For digits 3..1, if the nibble and all higher nibbles are zero, seg is forced to 7'h7F.
  - The anode still follows the scan, and dp still follows dp_in.
  - Digit 0 is always shown.
- Not defined: all four digits are always decoded.

## Structure
- Shared package seg7_pkg holds:
  - the state enum (WAIT, BLANK, DRIVE)
  - N_DIGITS=4
  - the SEG_OFF=7'h7F and AN_OFF=4'hF constants
  - the 16-entry hex font constant
- Natural sub-module: seg7_hex_decode, a combinational nibble→seg lookup. The scan FSM, buffers and handshake stay in seg7_scan_display.

## Test plan
- Reset, then 3 ticks with no value loaded → an sequence 1111 (BLANK, 16 cycles), 1110, 1111, 1101; seg=7'b1000000 during each DRIVE; frame_done pulses once, on the first tick.
- Load 16'h1F80 with dp_in=4'b0100, then run one full frame → next frame drives digit0 '0', digit1 '8', digit2 'F' with dp=0, digit3 '1'. value_ready is low from load until the boundary, then high the cycle after.
- Offer a second value while pending is full → value_ready=0 and the value is not accepted. After the boundary it is accepted and shown one frame later.
- Handshake in the same cycle as a 3→0 boundary → active is unchanged that frame and the new value appears the frame after.
- Tick during BLANK (BLANK_CYCLES=16, tick at cycle 5 of BLANK) → idx does not advance, no frame_done, and DRIVE shows the same digit.
- LEADING_ZERO_BLANK_EN with 16'h0042 → digits 3 and 2 seg=7'h7F, digit 1 shows '4', digit 0 shows '2'. With 16'h0000 only digit 0 shows '0'. Without the macro, 16'h0042 shows '0','0','4','2'.

Source files
------------

// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 4-digit seven-segment scan driver:
//   state_t   - scan FSM states (WAIT, BLANK, DRIVE)
//   N_DIGITS  - number of multiplexed digits
//   SEG_OFF   - all segments dark (active-low), {g,f,e,d,c,b,a}
//   AN_OFF    - all anodes off (active-low)
//   HEX_FONT  - active-low segment patterns for hex digits 0..F
// ----------------------------------------------------------------------------
package seg7_pkg;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   localparam int         N_DIGITS = 4;
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [3:0] AN_OFF   = 4'hF;

   // Index 0 is the leftmost element of the concatenation.
   localparam logic [0:15][6:0] HEX_FONT = {
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// ----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational nibble -> active-low seven-segment lookup.
// Ports:
//   nibble  in  4  hex value to display
//   blank   in  1  force all segments dark
//   seg     out 7  {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_OFF : HEX_FONT[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// ----------------------------------------------------------------------------
// seg7_scan_display
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each refresh tick blanks all anodes for BLANK_CYCLES clocks (anti-ghosting)
// and then drives the next digit. New values arrive over a valid/ready
// handshake into a pending buffer and are promoted to the displayed (active)
// buffer only at frame boundaries, so a frame never mixes two values.
//
// Parameters:
//   BLANK_CYCLES  blank clocks before each digit, 1..255, < tick period
// Ports:
//   clk           in  1   system clock
//   rst_n         in  1   asynchronous active-low reset
//   refresh_tick  in  1   single-cycle scan-advance pulse
//   value_in      in  16  four hex nibbles, [3:0] = rightmost digit 0
//   dp_in         in  4   decimal-point request per digit
//   value_valid   in  1   producer offers value_in/dp_in
//   value_ready   out 1   pending buffer empty (registered)
//   an            out 4   anodes, active-low
//   seg           out 7   {g,f,e,d,c,b,a}, active-low
//   dp            out 1   decimal point, active-low
//   frame_done    out 1   one-cycle pulse at each frame boundary
//
// Build option:
//   LEADING_ZERO_BLANK_EN - when defined, digits 3..1 go dark while they and
//   every higher nibble are zero; anodes and dp keep scanning normally.
// ----------------------------------------------------------------------------
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int unsigned BLANK_CYCLES = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        refresh_tick,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic        value_valid,
   output logic        value_ready,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  blank_cnt_q, blank_cnt_d;
   logic [15:0] active_val_q, active_val_d;
   logic [3:0]  active_dp_q, active_dp_d;
   logic [15:0] pend_val_q, pend_val_d;
   logic [3:0]  pend_dp_q, pend_dp_d;
   logic        pend_full_q, pend_full_d;
   logic        value_ready_q, value_ready_d;
   logic        frame_done_q, frame_done_d;
   logic [3:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;

   logic        boundary;
   logic        accept;
   logic [3:0]  nib_sel;
   logic        lz_blank;
   logic [6:0]  dec_seg;

   // Scan FSM, buffers and handshake
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      blank_cnt_d  = blank_cnt_q;
      active_val_d = active_val_q;
      active_dp_d  = active_dp_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_full_d  = pend_full_q;
      boundary     = 1'b0;
      accept       = value_valid && value_ready_q;

      case (state_q)
         WAIT: begin
            if (refresh_tick) begin
               state_d     = BLANK;
               idx_d       = 2'd0;
               blank_cnt_d = BLANK_LOAD;
               boundary    = 1'b1;
            end
         end
         BLANK: begin
            // Ticks are ignored here; only the counter moves the FSM on.
            if (blank_cnt_q == 8'd0) begin
               state_d = DRIVE;
            end else begin
               blank_cnt_d = blank_cnt_q - 8'd1;
            end
         end
         DRIVE: begin
            if (refresh_tick) begin
               state_d     = BLANK;
               idx_d       = idx_q + 2'd1;
               blank_cnt_d = BLANK_LOAD;
               boundary    = (idx_q == 2'd3);
            end
         end
         default: begin
            state_d = WAIT;
         end
      endcase

      // Promotion and acceptance never fight over pending: acceptance needs
      // pending empty, promotion needs it full. A same-cycle accept therefore
      // lands in pending and waits for the next boundary.
      if (boundary && pend_full_q) begin
         active_val_d = pend_val_q;
         active_dp_d  = pend_dp_q;
         pend_full_d  = 1'b0;
      end
      if (accept) begin
         pend_val_d  = value_in;
         pend_dp_d   = dp_in;
         pend_full_d = 1'b1;
      end
   end

   assign frame_done_d  = boundary;
   assign value_ready_d = !pend_full_d;

   // Outputs are registered, so they are computed from next-state values.
   assign nib_sel = active_val_d[{idx_d, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
   logic [3:0] zero_from;
   always_comb begin
      zero_from[3] = (active_val_d[15:12] == 4'h0);
      zero_from[2] = zero_from[3] && (active_val_d[11:8] == 4'h0);
      zero_from[1] = zero_from[2] && (active_val_d[7:4] == 4'h0);
      zero_from[0] = 1'b0;  // rightmost digit is always shown
   end
   assign lz_blank = zero_from[idx_d];
`else
   assign lz_blank = 1'b0;
`endif

   seg7_hex_decode u_dec (
      .nibble (nib_sel),
      .blank  (lz_blank),
      .seg    (dec_seg)
   );

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (state_d == DRIVE) begin
         an_d[idx_d] = 1'b0;
         seg_d       = dec_seg;
         dp_d        = ~active_dp_d[idx_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= WAIT;
         idx_q         <= 2'd0;
         blank_cnt_q   <= 8'd0;
         active_val_q  <= 16'h0000;
         active_dp_q   <= 4'h0;
         pend_val_q    <= 16'h0000;
         pend_dp_q     <= 4'h0;
         pend_full_q   <= 1'b0;
         value_ready_q <= 1'b1;
         frame_done_q  <= 1'b0;
         an_q          <= AN_OFF;
         seg_q         <= SEG_OFF;
         dp_q          <= 1'b1;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         blank_cnt_q   <= blank_cnt_d;
         active_val_q  <= active_val_d;
         active_dp_q   <= active_dp_d;
         pend_val_q    <= pend_val_d;
         pend_dp_q     <= pend_dp_d;
         pend_full_q   <= pend_full_d;
         value_ready_q <= value_ready_d;
         frame_done_q  <= frame_done_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign value_ready = value_ready_q;
   assign frame_done  = frame_done_q;
   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_display
// Directed testbench for seg7_scan_display. Inputs change on the falling
// edge, outputs are sampled on the falling edge before inputs change.
// Honors LEADING_ZERO_BLANK_EN for the expected leading-zero segments.
// ----------------------------------------------------------------------------
module tb_seg7_scan_display;

   localparam int BLANK_CYCLES = 16;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        refresh_tick = 1'b0;
   logic [15:0] value_in = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic        value_valid = 1'b0;
   logic        value_ready;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   seg7_scan_display #(.BLANK_CYCLES(BLANK_CYCLES)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .refresh_tick (refresh_tick),
      .value_in     (value_in),
      .dp_in        (dp_in),
      .value_valid  (value_valid),
      .value_ready  (value_ready),
      .an           (an),
      .seg          (seg),
      .dp           (dp),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Optional handshake presented in the same cycle as the next tick.
   logic        hs_valid = 1'b0;
   logic [15:0] hs_value = 16'h0;
   logic [3:0]  hs_dp    = 4'h0;

   typedef struct {
      logic [15:0] val;
      logic [3:0]  dpv;
      logic [27:0] segs;   // {seg3, seg2, seg1, seg0}
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_tick();
      refresh_tick = 1'b1;
      value_valid  = hs_valid;
      if (hs_valid) begin
         value_in = hs_value;
         dp_in    = hs_dp;
      end
      @(negedge clk);
      refresh_tick = 1'b0;
      value_valid  = 1'b0;
      hs_valid     = 1'b0;
   endtask

   // Tick into the blank of digit idx, check the blank window, then the drive.
   task automatic scan_digit(input string tag, input int idx, input logic [6:0] eseg,
                             input logic edp, input logic efd, input logic erdy);
      logic [3:0] ean;
      string      t;
      ean      = 4'hF;
      ean[idx] = 1'b0;
      t = $sformatf("%s_d%0d", tag, idx);
      do_tick();
      check({t, "_fd"},        32'(frame_done),  32'(efd));
      check({t, "_rdy"},       32'(value_ready), 32'(erdy));
      check({t, "_blank_an"},  32'(an),          32'hF);
      check({t, "_blank_seg"}, 32'(seg),         32'h7F);
      repeat (BLANK_CYCLES - 1) @(negedge clk);
      check({t, "_blank_end_an"}, 32'(an),         32'hF);
      check({t, "_fd_low"},       32'(frame_done), 32'h0);
      @(negedge clk);
      check({t, "_an"},  32'(an),  32'(ean));
      check({t, "_seg"}, 32'(seg), 32'(eseg));
      check({t, "_dp"},  32'(dp),  32'(edp));
   endtask

   // Starting from DRIVE of digit 3, scan a whole frame starting at the boundary.
   task automatic run_frame(input string tag, input logic [27:0] segs,
                            input logic [3:0] dps, input logic erdy);
      for (int i = 0; i < 4; i++)
         scan_digit(tag, i, segs[i*7 +: 7], ~dps[i], (i == 0), erdy);
   endtask

   task automatic load(input string tag, input logic [15:0] v, input logic [3:0] d);
      check({tag, "_rdy_before"}, 32'(value_ready), 32'h1);
      value_valid = 1'b1;
      value_in    = v;
      dp_in       = d;
      @(negedge clk);
      value_valid = 1'b0;
      check({tag, "_rdy_after"}, 32'(value_ready), 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{16'h0123, 4'b0001, {LZ,    7'h79, 7'h24, 7'h30}};
      tbl[1] = '{16'h4567, 4'b1000, {7'h19, 7'h12, 7'h02, 7'h78}};
      tbl[2] = '{16'h89AB, 4'b0110, {7'h00, 7'h10, 7'h08, 7'h03}};
      tbl[3] = '{16'hCDEF, 4'b1111, {7'h46, 7'h21, 7'h06, 7'h0E}};
      tbl[4] = '{16'h0042, 4'b0000, {LZ,    LZ,    7'h19, 7'h24}};
      tbl[5] = '{16'h0000, 4'b0010, {LZ,    LZ,    LZ,    7'h40}};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_an",  32'(an),          32'hF);
      check("rst_seg", 32'(seg),         32'h7F);
      check("rst_dp",  32'(dp),          32'h1);
      check("rst_rdy", 32'(value_ready), 32'h1);
      check("rst_fd",  32'(frame_done),  32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("wait_an", 32'(an), 32'hF);

      // Three ticks, nothing loaded: active is zero
      scan_digit("t1", 0, 7'h40, 1'b1, 1'b1, 1'b1);
      scan_digit("t1", 1, LZ,    1'b1, 1'b0, 1'b1);
      scan_digit("t1", 2, LZ,    1'b1, 1'b0, 1'b1);

      // Load 1F80, finish current frame, next frame shows it
      load("t2_load", 16'h1F80, 4'b0100);
      scan_digit("t2pre", 3, LZ, 1'b1, 1'b0, 1'b0);
      check("t2_rdy_before_boundary", 32'(value_ready), 32'h0);
      run_frame("t2", {7'h79, 7'h0E, 7'h00, 7'h40}, 4'b0100, 1'b1);

      // Second value offered while pending is full is refused
      load("t3_load", 16'h2345, 4'b0000);
      value_valid = 1'b1;
      value_in    = 16'hABCD;
      dp_in       = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("t3_busy_rdy%0d", i), 32'(value_ready), 32'h0);
      end
      value_valid = 1'b0;
      run_frame("t3a", {7'h24, 7'h30, 7'h19, 7'h12}, 4'b0000, 1'b1);
      load("t3_reload", 16'hABCD, 4'b0000);
      run_frame("t3b", {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0000, 1'b1);

      // Handshake on the same edge as the 3->0 boundary
      hs_valid = 1'b1;
      hs_value = 16'h6789;
      hs_dp    = 4'b1001;
      scan_digit("t4", 0, 7'h21, 1'b1, 1'b1, 1'b0);
      scan_digit("t4", 1, 7'h46, 1'b1, 1'b0, 1'b0);
      scan_digit("t4", 2, 7'h03, 1'b1, 1'b0, 1'b0);
      scan_digit("t4", 3, 7'h08, 1'b1, 1'b0, 1'b0);
      run_frame("t4b", {7'h02, 7'h78, 7'h00, 7'h10}, 4'b1001, 1'b1);

      // Tick during BLANK is ignored
      do_tick();
      check("t5_fd_boundary", 32'(frame_done), 32'h1);
      repeat (4) @(negedge clk);
      refresh_tick = 1'b1;
      @(negedge clk);
      refresh_tick = 1'b0;
      check("t5_fd_ignored", 32'(frame_done), 32'h0);
      check("t5_an_blank",   32'(an),         32'hF);
      repeat (BLANK_CYCLES - 6) @(negedge clk);
      check("t5_an_blank_end", 32'(an), 32'hF);
      @(negedge clk);
      check("t5_an",  32'(an),  32'hE);
      check("t5_seg", 32'(seg), 32'h10);
      check("t5_dp",  32'(dp),  32'h0);
      scan_digit("t5", 1, 7'h00, 1'b1, 1'b0, 1'b1);
      scan_digit("t5", 2, 7'h78, 1'b1, 1'b0, 1'b1);
      scan_digit("t5", 3, 7'h02, 1'b0, 1'b0, 1'b1);

      // Table-driven decode frames
      for (int v = 0; v < 6; v++) begin
         load($sformatf("tbl%0d_load", v), tbl[v].val, tbl[v].dpv);
         run_frame($sformatf("tbl%0d", v), tbl[v].segs, tbl[v].dpv, 1'b1);
      end

      // Reset mid-operation discards pending and active
      load("rst_load", 16'h1234, 4'hF);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_an",  32'(an),          32'hF);
      check("mid_rst_seg", 32'(seg),         32'h7F);
      check("mid_rst_dp",  32'(dp),          32'h1);
      check("mid_rst_rdy", 32'(value_ready), 32'h1);
      check("mid_rst_fd",  32'(frame_done),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame("post_rst", {LZ, LZ, LZ, 7'h40}, 4'b0000, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
